// File: rtl/mux_channel_sequencer.sv
// Scans the enabled channels of an 8-to-1 data mux in ascending order.
// Each channel is settled, captured and offered downstream on a valid/ready handshake.
module mux_channel_sequencer #(
  parameter int N_BITS        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        channel_mask,
  input  logic [N_BITS-1:0] mux_data_i,
  output logic [2:0]        selector_o,
  output logic [N_BITS-1:0] data_o,
  output logic [2:0]        channel_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SETTLE,
    HOLD,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     next_state;
  logic [7:0] mask_q;
  logic [3:0] pointer;
  logic [3:0] settle_cnt;
  logic       hit;
  logic [2:0] hit_idx;
  logic       handshake;

  assign handshake = valid_o && ready_i;

  // Lowest enabled channel at or above the pointer; pointer value 8 finds nothing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) >= pointer)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SCAN;
        end
      end
      SCAN: begin
        next_state = hit ? SETTLE : DONE;
      end
      SETTLE: begin
        if (settle_cnt <= 4'd1) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          next_state = (channel_o == 3'd7) ? DONE : SCAN;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // busy_o stays up through the cycle in which done_o is shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      selector_o <= 3'd0;
      data_o     <= '0;
      channel_o  <= 3'd0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      mask_q     <= 8'd0;
      pointer    <= 4'd0;
      settle_cnt <= 4'd0;
    end else begin
      done_o <= (state == DONE);
      busy_o <= (next_state != IDLE) || (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            mask_q  <= channel_mask;
            pointer <= 4'd0;
          end
        end
        SCAN: begin
          if (hit) begin
            selector_o <= hit_idx;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) begin
            data_o    <= mux_data_i;
            channel_o <= selector_o;
            valid_o   <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_o <= 1'b0;
            pointer <= {1'b0, channel_o} + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_channel_sequencer.sv
// Randomized self-checking bench for mux_channel_sequencer.
// Expected samples come from the latched mask and a mux data table; timing from latency rules.
module tb_mux_channel_sequencer;

  localparam int S1 = 1;
  localparam int S4 = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] channel_mask;
  logic [7:0] mux_data;
  logic [2:0] selector_o;
  logic [7:0] data_o;
  logic [2:0] channel_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       done_o;

  logic       start4;
  logic [7:0] mask4;
  logic [7:0] mux4;
  logic [2:0] sel4;
  logic [7:0] data4;
  logic [2:0] ch4;
  logic       valid4;
  logic       ready4;
  logic       busy4;
  logic       done4;

  logic [7:0] data_tab [8];

  int checks;
  int errors;

  assign mux_data = data_tab[selector_o];

  mux_channel_sequencer #(.N_BITS(8), .SETTLE_CYCLES(S1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .channel_mask(channel_mask),
    .mux_data_i(mux_data), .selector_o(selector_o), .data_o(data_o),
    .channel_o(channel_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  mux_channel_sequencer #(.N_BITS(8), .SETTLE_CYCLES(S4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .channel_mask(mask4),
    .mux_data_i(mux4), .selector_o(sel4), .data_o(data4),
    .channel_o(ch4), .valid_o(valid4), .ready_i(ready4),
    .busy_o(busy4), .done_o(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] packed_outs();
    return {15'd0, selector_o, data_o, channel_o, valid_o, busy_o, done_o};
  endfunction

  // One complete scan; k counts the most recent clock edge, the start edge being 0.
  // stall < 0 picks a random 0..3 cycle backpressure per sample.
  task automatic apply_stimulus(input logic [7:0] mask, input int stall, input bit disturb);
    int         exp_q[$];
    int         k;
    int         last_ev;
    int         last_hs;
    int         last_ch;
    int         wait_cnt;
    int         cur_stall;
    int         exp_done;
    bit         seen_done;
    logic       prev_valid;
    logic [2:0] prev_sel;
    logic [7:0] prev_data;
    logic [2:0] prev_ch;

    for (int i = 0; i < 8; i++) begin
      if (mask[i]) exp_q.push_back(i);
    end
    channel_mask = mask;
    start        = 1'b1;
    ready_i      = 1'b0;
    tick();
    start      = 1'b0;
    k          = 0;
    last_ev    = 0;
    last_hs    = -1;
    last_ch    = -1;
    wait_cnt   = 0;
    cur_stall  = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    seen_done  = 1'b0;
    prev_valid = 1'b0;
    prev_sel   = selector_o;
    prev_data  = data_o;
    prev_ch    = channel_o;
    check_output("busy_after_start", {31'd0, busy_o}, 32'd1);

    while (!seen_done && k < 3000) begin
      if (selector_o != prev_sel) begin
        check_output("sel_in_mask", {31'd0, mask[selector_o]}, 32'd1);
      end
      prev_sel = selector_o;

      if (k == last_hs) begin
        check_output("valid_clear", {31'd0, valid_o}, 32'd0);
      end

      if (valid_o && !prev_valid) begin
        check_output("valid_latency", k, last_ev + S1 + 1);
        if (exp_q.size() == 0) begin
          check_output("extra_sample", {29'd0, channel_o}, 32'hFFFF_FFFF);
        end else begin
          check_output("sample_ch", {29'd0, channel_o}, exp_q[0]);
          check_output("sample_data", {24'd0, data_o}, {24'd0, data_tab[exp_q[0]]});
        end
        check_output("sel_eq_ch", {29'd0, selector_o}, {29'd0, channel_o});
        wait_cnt  = 0;
        prev_data = data_o;
        prev_ch   = channel_o;
      end else if (valid_o) begin
        check_output("hold_stable", {21'd0, data_o, channel_o}, {21'd0, prev_data, prev_ch});
      end

      if (done_o) begin
        seen_done = 1'b1;
        if (mask == 8'd0) exp_done = 2;
        else exp_done = last_hs + ((last_ch == 7) ? 1 : 2);
        check_output("done_timing", k, exp_done);
        check_output("done_all_samples", exp_q.size(), 0);
        check_output("busy_with_done", {31'd0, busy_o}, 32'd1);
      end

      if (valid_o) begin
        ready_i = (wait_cnt >= cur_stall);
        if (ready_i) begin
          last_hs   = k + 1;
          last_ev   = k + 1;
          last_ch   = int'(channel_o);
          cur_stall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        wait_cnt++;
      end else begin
        ready_i = 1'($urandom_range(0, 1));
      end

      if (disturb && !seen_done) begin
        start        = 1'($urandom_range(0, 1));
        channel_mask = 8'($urandom);
      end else begin
        start = 1'b0;
      end

      prev_valid = valid_o;
      tick();
      k++;
    end

    start   = 1'b0;
    ready_i = 1'b0;
    if (!seen_done) begin
      check_output("scan_timeout", 32'd0, 32'd1);
    end
    check_output("idle_after_done", {30'd0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    start        = 1'b0;
    channel_mask = 8'd0;
    ready_i      = 1'b0;
    start4       = 1'b0;
    mask4        = 8'd0;
    mux4         = 8'd0;
    ready4       = 1'b0;
    for (int i = 0; i < 8; i++) data_tab[i] = 8'hA0 + 8'(i);

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_output($sformatf("idle_outs_%0d", c), packed_outs(), 32'd0);
    end
    check_output("idle_outs_dut4", {15'd0, sel4, data4, ch4, valid4, busy4, done4}, 32'd0);

    // Full scan with ready held high
    apply_stimulus(8'hFF, 0, 1'b0);

    // Sparse mask with backpressure
    for (int i = 0; i < 8; i++) data_tab[i] = 8'($urandom);
    apply_stimulus(8'b1000_0101, 5, 1'b0);

    // Empty mask, then a full scan disturbed by start pulses and mask changes
    apply_stimulus(8'h00, 0, 1'b0);
    apply_stimulus(8'hFF, -1, 1'b1);

    // Randomized scans
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) data_tab[i] = 8'($urandom);
      apply_stimulus(8'($urandom), -1, 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 3))) tick();
    end

    // Longer settle: data changes two cycles after the selector moves
    mux4   = 8'h11;
    mask4  = 8'h08;
    ready4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) check_output("settle_sel", {29'd0, sel4}, 32'd3);
      if (k == 3) mux4 = 8'h5A;
      check_output($sformatf("settle_valid_k%0d", k), {31'd0, valid4}, {31'd0, k == 5});
    end
    check_output("settle_data", {24'd0, data4}, 32'h5A);
    check_output("settle_ch", {29'd0, ch4}, 32'd3);
    ready4 = 1'b1;
    tick();
    ready4 = 1'b0;
    check_output("settle_valid_clear", {31'd0, valid4}, 32'd0);
    tick();
    check_output("settle_done_early", {31'd0, done4}, 32'd0);
    tick();
    check_output("settle_done", {31'd0, done4}, 32'd1);

    // Reset asserted while holding a sample
    channel_mask = 8'hFF;
    ready_i      = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!valid_o && guard < 20) begin
        tick();
        guard++;
      end
      check_output("hold_reached", {31'd0, valid_o}, 32'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_outs", packed_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_output("post_reset_idle", packed_outs(), 32'd0);
    for (int i = 0; i < 8; i++) data_tab[i] = 8'hA0 + 8'(i);
    apply_stimulus(8'hFF, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
